// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, optional msip, single-cycle bus port.
// Optional software-interrupt register enabled by defining MACHINE_TIMER_MSIP_EN.
module machine_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_timer_interrupt,
  output logic        o_software_interrupt
);

  localparam int unsigned TICK_W = 16;
  localparam int unsigned WORD_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;

  localparam logic [WORD_W-1:0] W_MTIME_LO = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_MTIME_HI = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_CMP_LO   = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_CMP_HI   = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_MSIP     = WORD_W'(4);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TIME_W-1:0] mtime_q, mtime_d;
  logic [TIME_W-1:0] mtimecmp_q, mtimecmp_d;
  logic [DATA_W-1:0] rdata_d;
  logic [WORD_W-1:0] word;
  logic              wr;
  logic              rd;
  logic              tick;
  logic              msip_rd;
  logic              unused_addr;

  assign word        = i_addr[4:2];
  assign wr          = i_req & i_we;
  assign rd          = i_req & ~i_we;
  assign unused_addr = ^i_addr[1:0];

  // Prescaler: tick fires on the last count of each TICK_DIV-cycle period
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick       = 1'b1;
      tick_cnt_d = '0;
    end
  end

  // A write to either mtime half wins over the increment, without carry
  always_comb begin
    mtime_d = mtime_q;
    if (wr && word == W_MTIME_LO) begin
      mtime_d[31:0] = i_wdata;
    end else if (wr && word == W_MTIME_HI) begin
      mtime_d[63:32] = i_wdata;
    end else if (tick) begin
      mtime_d = mtime_q + TIME_W'(1);
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && word == W_CMP_LO) begin
      mtimecmp_d[31:0] = i_wdata;
    end else if (wr && word == W_CMP_HI) begin
      mtimecmp_d[63:32] = i_wdata;
    end
  end

`ifdef MACHINE_TIMER_MSIP_EN
  logic msip_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      msip_q <= 1'b0;
    end else if (wr && word == W_MSIP) begin
      msip_q <= i_wdata[0];
    end
  end

  assign msip_rd              = msip_q;
  assign o_software_interrupt = msip_q;
`else
  assign msip_rd              = 1'b0;
  assign o_software_interrupt = 1'b0;
`endif

  // Read mux samples pre-update register state; writes acknowledge with zero data
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (word)
        W_MTIME_LO: rdata_d = mtime_q[31:0];
        W_MTIME_HI: rdata_d = mtime_q[63:32];
        W_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        W_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        W_MSIP:     rdata_d = {31'b0, msip_rd};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tick_cnt_q        <= '0;
      mtime_q           <= '0;
      mtimecmp_q        <= '1;
      o_ack             <= 1'b0;
      o_rdata           <= '0;
      o_timer_interrupt <= 1'b0;
    end else begin
      tick_cnt_q        <= tick_cnt_d;
      mtime_q           <= mtime_d;
      mtimecmp_q        <= mtimecmp_d;
      o_ack             <= i_req;
      o_rdata           <= rdata_d;
      o_timer_interrupt <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule
